icache_axi_rd_bridge: RTL and testbench

- Responder on the instruction-cache refill interface: accepts one line-read request (rd_req/rd_addr) from the ICache miss path, issues one AXI4 INCR burst read, assembles the beats into a full cache line, returns it with a single-cycle ret_valid.
- Sits between the ICache AXI-facing port and the SoC AXI read channel. One outstanding request at a time.

---
 rtl/icache_axi_rd_bridge_if.sv | 43 ++++
 rtl/icache_axi_rd_bridge.sv | 132 +++++++++++++
 tb/tb_icache_axi_rd_bridge.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/icache_axi_rd_bridge_if.sv
// Bundle of the ICache refill request/return signals and the AXI4 read channels.
// The master modport is the bridge's view. The slave modport is the view of
// the surrounding system: the ICache miss path plus the SoC AXI read port.
interface icache_axi_rd_bridge_if #(
  parameter int LINE_WORDS = 4
);
  // ICache side
  logic                       rd_req;
  logic [31:0]                rd_addr;
  logic                       rd_rdy;
  logic                       ret_valid;
  logic [LINE_WORDS*32-1:0]   ret_data;
  // AXI AR channel
  logic [3:0]                 arid;
  logic [31:0]                araddr;
  logic [7:0]                 arlen;
  logic [2:0]                 arsize;
  logic [1:0]                 arburst;
  logic                       arvalid;
  logic                       arready;
  // AXI R channel
  logic [3:0]                 rid;
  logic [31:0]                rdata;
  logic [1:0]                 rresp;
  logic                       rlast;
  logic                       rvalid;
  logic                       rready;
  // Performance counters
  logic [31:0]                perf_req_cnt;
  logic [31:0]                perf_busy_cyc;

  modport master (
    input  rd_req, rd_addr, arready, rid, rdata, rresp, rlast, rvalid,
    output rd_rdy, ret_valid, ret_data, arid, araddr, arlen, arsize, arburst,
           arvalid, rready, perf_req_cnt, perf_busy_cyc
  );

  modport slave (
    output rd_req, rd_addr, arready, rid, rdata, rresp, rlast, rvalid,
    input  rd_rdy, ret_valid, ret_data, arid, araddr, arlen, arsize, arburst,
           arvalid, rready, perf_req_cnt, perf_busy_cyc
  );
endinterface

// File: rtl/icache_axi_rd_bridge.sv
// ICache line-refill bridge.
// It accepts one line-read request and issues a single AXI4 INCR burst.
// It assembles the returned beats into a cache line and presents the line
// with a one-cycle ret_valid pulse. Only one request is outstanding at a time.
// Optional performance counters are built when ICACHE_AXI_RD_PERF_EN is defined.
// Without that macro, perf_req_cnt and perf_busy_cyc read 0.
module icache_axi_rd_bridge #(
  parameter int         LINE_WORDS = 4,
  parameter logic [3:0] ARID_VAL   = 4'b0000
) (
  input  logic                  clk,
  input  logic                  resetn,
  icache_axi_rd_bridge_if.master bus
);

  localparam int OFF = $clog2(LINE_WORDS * 4);  // byte-offset bits within a line
  localparam int BW  = $clog2(LINE_WORDS);      // beat counter width

  typedef enum logic [1:0] {IDLE, AR, R, RET} state_t;

  state_t                   state_q, state_d;
  logic [31:0]              araddr_q, araddr_d;
  logic [BW-1:0]            beat_q, beat_d;
  // Set once the last word slot is written; extra beats are then dropped
  // instead of wrapping the counter.
  logic                     full_q, full_d;
  logic [LINE_WORDS*32-1:0] line_q, line_d;

  // Next-state, address latch, beat counter and line assembly
  always_comb begin
    state_d  = state_q;
    araddr_d = araddr_q;
    beat_d   = beat_q;
    full_d   = full_q;
    line_d   = line_q;
    case (state_q)
      IDLE: begin
        if (bus.rd_req) begin
          araddr_d = {bus.rd_addr[31:OFF], {OFF{1'b0}}};
          line_d   = '0;
          beat_d   = '0;
          full_d   = 1'b0;
          state_d  = AR;
        end
      end
      AR: begin
        if (bus.arready) state_d = R;
      end
      R: begin
        if (bus.rvalid) begin
          if (!full_q) begin
            for (int i = 0; i < LINE_WORDS; i++) begin
              if (beat_q == BW'(i)) line_d[i*32 +: 32] = bus.rdata;
            end
            if (beat_q == BW'(LINE_WORDS - 1)) full_d = 1'b1;
            else                               beat_d = beat_q + 1'b1;
          end
          // An early rlast still completes the line; unfilled words stay 0.
          if (bus.rlast) state_d = RET;
        end
      end
      RET: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= IDLE;
      araddr_q <= '0;
      beat_q   <= '0;
      full_q   <= 1'b0;
      line_q   <= '0;
    end else begin
      state_q  <= state_d;
      araddr_q <= araddr_d;
      beat_q   <= beat_d;
      full_q   <= full_d;
      line_q   <= line_d;
    end
  end

  assign bus.rd_rdy    = (state_q == IDLE);
  assign bus.arvalid   = (state_q == AR);
  assign bus.rready    = (state_q == R);
  assign bus.ret_valid = (state_q == RET);
  assign bus.ret_data  = line_q;
  assign bus.araddr    = araddr_q;
  assign bus.arid      = ARID_VAL;
  assign bus.arlen     = 8'(LINE_WORDS - 1);
  assign bus.arsize    = 3'b010;
  assign bus.arburst   = 2'b01;

  // The response ID, the response code and the line-offset address bits carry
  // no information for this bridge.
  logic unused_ok;
  assign unused_ok = ^{bus.rid, bus.rresp, bus.rd_addr[OFF-1:0]};

`ifdef ICACHE_AXI_RD_PERF_EN
  logic [31:0] perf_req_cnt_q, perf_req_cnt_d;
  logic [31:0] perf_busy_cyc_q, perf_busy_cyc_d;

  // Count completed refills and cycles spent away from IDLE (wrapping)
  always_comb begin
    perf_req_cnt_d  = perf_req_cnt_q;
    perf_busy_cyc_d = perf_busy_cyc_q;
    if (state_q == RET)  perf_req_cnt_d  = perf_req_cnt_q + 32'd1;
    if (state_q != IDLE) perf_busy_cyc_d = perf_busy_cyc_q + 32'd1;
  end

  // Performance counter registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      perf_req_cnt_q  <= '0;
      perf_busy_cyc_q <= '0;
    end else begin
      perf_req_cnt_q  <= perf_req_cnt_d;
      perf_busy_cyc_q <= perf_busy_cyc_d;
    end
  end

  assign bus.perf_req_cnt  = perf_req_cnt_q;
  assign bus.perf_busy_cyc = perf_busy_cyc_q;
`else
  assign bus.perf_req_cnt  = 32'd0;
  assign bus.perf_busy_cyc = 32'd0;
`endif

endmodule

// File: tb/tb_icache_axi_rd_bridge.sv
// Directed self-checking bench for icache_axi_rd_bridge.
// Expected perf values follow ICACHE_AXI_RD_PERF_EN.
module tb_icache_axi_rd_bridge;
  localparam int LW = 4;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  icache_axi_rd_bridge_if #(.LINE_WORDS(LW)) bus ();

  icache_axi_rd_bridge #(.LINE_WORDS(LW), .ARID_VAL(4'b0000)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] beats [8];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic last);
    bus.rvalid = 1'b1;
    bus.rdata  = d;
    bus.rlast  = last;
    step();
    bus.rvalid = 1'b0;
    bus.rlast  = 1'b0;
    bus.rdata  = '0;
  endtask

  // One complete refill with arready=1 and nb back-to-back beats from beats[].
  task automatic refill(input string tag, input logic [31:0] addr, input int nb,
                        input logic [127:0] exp);
    bus.rd_req  = 1'b1;
    bus.rd_addr = addr;
    bus.arready = 1'b1;
    step();
    bus.rd_req = 1'b0;
    step();
    for (int i = 0; i < nb; i++) send_beat(beats[i], (i == nb - 1));
    chk({tag, "_ret_valid"}, bus.ret_valid, 1);
    chk({tag, "_ret_data"}, bus.ret_data, exp);
    $display("[TB] %s refill addr=0x%08h beats=%0d data=0x%032h", tag, addr, nb, bus.ret_data);
    step();
    chk({tag, "_ret_pulse_end"}, bus.ret_valid, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus.rd_req = 0; bus.rd_addr = '0; bus.arready = 0; bus.rid = '0;
    bus.rdata = '0; bus.rresp = '0; bus.rlast = 0; bus.rvalid = 0;

    // ---------------- reset ----------------
    step(); step();
    chk("rst_arvalid", bus.arvalid, 0);
    chk("rst_rready", bus.rready, 0);
    chk("rst_ret_valid", bus.ret_valid, 0);
    resetn = 1'b1;
    step();
    chk("rst_rd_rdy", bus.rd_rdy, 1);
    chk("rst_araddr", bus.araddr, 0);
    chk("rst_ret_data", bus.ret_data, 0);
    chk("rst_perf_req", bus.perf_req_cnt, 0);
    chk("rst_perf_busy", bus.perf_busy_cyc, 0);

    // ---------------- basic refill, latency 6 ----------------
    bus.rd_req = 1; bus.rd_addr = 32'h1FC0_0014; bus.arready = 1;
    step();                                   // cycle 1: AR
    bus.rd_req = 0;
    chk("t1_arvalid", bus.arvalid, 1);
    chk("t1_araddr", bus.araddr, 32'h1FC0_0010);
    chk("t1_arlen", bus.arlen, 3);
    chk("t1_arsize", bus.arsize, 2);
    chk("t1_arburst", bus.arburst, 1);
    chk("t1_arid", bus.arid, 0);
    chk("t1_rd_rdy_ar", bus.rd_rdy, 0);
    step();                                   // cycle 2: R
    chk("t1_rready", bus.rready, 1);
    chk("t1_arvalid_r", bus.arvalid, 0);
    beats[0] = 32'h1111_1111; beats[1] = 32'h2222_2222;
    beats[2] = 32'h3333_3333; beats[3] = 32'h4444_4444;
    for (int i = 0; i < 4; i++) begin
      chk("t1_no_early_ret", bus.ret_valid, 0);
      send_beat(beats[i], (i == 3));
    end                                       // now cycle 6
    chk("t1_ret_valid_c6", bus.ret_valid, 1);
    chk("t1_rd_rdy_ret", bus.rd_rdy, 0);
    chk("t1_ret_data", bus.ret_data, 128'h44444444_33333333_22222222_11111111);
    $display("[TB] t1 refill addr=0x1fc00014 data=0x%032h", bus.ret_data);
    step();
    chk("t1_ret_pulse_end", bus.ret_valid, 0);
    chk("t1_rd_rdy_idle", bus.rd_rdy, 1);
    chk("t1_ret_data_hold", bus.ret_data, 128'h44444444_33333333_22222222_11111111);

    // ---------------- AR backpressure + R gaps ----------------
    bus.arready = 0; bus.rd_req = 1; bus.rd_addr = 32'h0000_1238;
    step();
    bus.rd_req = 0;
    for (int k = 0; k < 3; k++) begin
      chk("t2_arvalid_held", bus.arvalid, 1);
      chk("t2_araddr_stable", bus.araddr, 32'h0000_1230);
      chk("t2_rd_rdy_ar", bus.rd_rdy, 0);
      step();
    end
    bus.arready = 1;
    chk("t2_arvalid_at_hs", bus.arvalid, 1);
    step();
    bus.arready = 0;
    beats[0] = 32'hDEAD_BEEF; beats[1] = 32'h0123_4567;
    beats[2] = 32'h89AB_CDEF; beats[3] = 32'hCAFE_F00D;
    for (int i = 0; i < 4; i++) begin
      send_beat(beats[i], (i == 3));
      if (i != 3) begin
        chk("t2_rd_rdy_r", bus.rd_rdy, 0);
        step();                               // one-cycle rvalid gap
      end
    end
    chk("t2_ret_valid", bus.ret_valid, 1);
    chk("t2_ret_data", bus.ret_data, 128'hCAFEF00D_89ABCDEF_01234567_DEADBEEF);
    $display("[TB] t2 refill addr=0x00001238 data=0x%032h", bus.ret_data);
    step();

    // ---------------- early rlast ----------------
    beats[0] = 32'h0000_000A; beats[1] = 32'h0000_000B;
    refill("t3_early", 32'h0000_0040, 2, 128'h00000000_00000000_0000000B_0000000A);

    // ---------------- beats past the line are dropped ----------------
    beats[0] = 32'h1; beats[1] = 32'h2; beats[2] = 32'h3; beats[3] = 32'h4; beats[4] = 32'h5;
    refill("t3_extra", 32'h0000_0080, 5, 128'h00000004_00000003_00000002_00000001);

    // ---------------- back-to-back, request during R ignored ----------------
    bus.rd_req = 1; bus.rd_addr = 32'h0000_2000; bus.arready = 1;
    step();                                   // AR
    bus.rd_addr = 32'h0000_3000;              // rd_req stays high: must be ignored
    step();                                   // R
    for (int i = 0; i < 4; i++) begin
      chk("t4_araddr_kept", bus.araddr, 32'h0000_2000);
      chk("t4_rd_rdy_r", bus.rd_rdy, 0);
      send_beat(32'hA0 + 32'(i), (i == 3));
    end
    bus.rd_req = 0;
    chk("t4_ret_a_valid", bus.ret_valid, 1);
    chk("t4_ret_a_data", bus.ret_data, 128'h000000A3_000000A2_000000A1_000000A0);
    $display("[TB] t4 refill addr=0x00002000 data=0x%032h", bus.ret_data);
    step();                                   // IDLE, one cycle after ret_valid
    chk("t4_idle_rdy", bus.rd_rdy, 1);
    chk("t4_idle_no_ret", bus.ret_valid, 0);
    bus.rd_req = 1;
    step();
    bus.rd_req = 0;
    chk("t4_second_accepted", bus.arvalid, 1);
    chk("t4_second_araddr", bus.araddr, 32'h0000_3000);
    step();
    for (int i = 0; i < 4; i++) send_beat(32'hB0 + 32'(i), (i == 3));
    chk("t4_ret_b_valid", bus.ret_valid, 1);
    chk("t4_ret_b_data", bus.ret_data, 128'h000000B3_000000B2_000000B1_000000B0);
    $display("[TB] t4 refill addr=0x00003000 data=0x%032h", bus.ret_data);
    step();

    // ---------------- reset mid-burst ----------------
    bus.rd_req = 1; bus.rd_addr = 32'h0000_4000; bus.arready = 1;
    step();
    bus.rd_req = 0;
    step();
    send_beat(32'h5555_0000, 0);
    send_beat(32'h5555_0001, 0);
    resetn = 0;
    step();
    chk("t5_rst_arvalid", bus.arvalid, 0);
    chk("t5_rst_rready", bus.rready, 0);
    chk("t5_rst_ret_valid", bus.ret_valid, 0);
    chk("t5_rst_ret_data", bus.ret_data, 0);
    resetn = 1;
    step();
    chk("t5_rd_rdy_after", bus.rd_rdy, 1);
    beats[0] = 32'hF0F0_0001; beats[1] = 32'hF0F0_0002;
    beats[2] = 32'hF0F0_0003; beats[3] = 32'hF0F0_0004;
    refill("t5_fresh", 32'h0000_5004, 4, 128'hF0F00004_F0F00003_F0F00002_F0F00001);

    // ---------------- perf counters (cleared by the mid-burst reset) ----------------
`ifdef ICACHE_AXI_RD_PERF_EN
    chk("t6_perf_req_1", bus.perf_req_cnt, 1);
    chk("t6_perf_busy_1", bus.perf_busy_cyc, 6);   // AR + 4xR + RET
`else
    chk("t6_perf_req_1", bus.perf_req_cnt, 0);
    chk("t6_perf_busy_1", bus.perf_busy_cyc, 0);
`endif
    refill("t6_second", 32'h0000_6000, 4, 128'hF0F00004_F0F00003_F0F00002_F0F00001);
`ifdef ICACHE_AXI_RD_PERF_EN
    chk("t6_perf_req_2", bus.perf_req_cnt, 2);
    chk("t6_perf_busy_2", bus.perf_busy_cyc, 12);
`else
    chk("t6_perf_req_2", bus.perf_req_cnt, 0);
    chk("t6_perf_busy_2", bus.perf_busy_cyc, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
